// File: rtl/float_div_pkg.sv
// Shared definitions for the divider issuer: default width, FSM states, qNaN constant.
package float_div_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam logic [31:0] QNAN32         = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/float_op_fifo.sv
// Operand-pair FIFO: power-of-2 depth, extra pointer bit separates full from empty.
module float_op_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/float_div_issuer.sv
// Feeder for the iterative single-precision divider: queues operand pairs, issues
// one at a time with a one-cycle div_enb, captures the quotient into a result stream.
// Optional watchdog in WAIT enabled by defining FLOAT_DIV_TIMEOUT_EN.
module float_div_issuer
  import float_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ACK_BLANK  = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic                  out_err,
  output logic                  div_enb,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  input  logic [DATA_WIDTH-1:0] div_c,
  input  logic                  div_ack,
  output logic                  busy
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned BW = (ACK_BLANK < 1) ? 1 : $clog2(ACK_BLANK + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_BLANK < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("float_div_issuer: illegal DEPTH/ACK_BLANK/TIMEOUT");
  end

  state_t        state;
  logic [BW-1:0] blank;
  logic [PW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          ack_ok;

`ifdef FLOAT_DIV_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;
  // A new op starts from IDLE or directly on the OUT handshake (back-to-back).
  assign pop      = !empty && ((state == IDLE) || ((state == OUT) && out_ready));
  assign ack_ok   = (blank == '0) && div_ack;

  float_op_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Issue FSM; the enb cycle counts as the first blanked cycle of the ack window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_enb   <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      blank     <= '0;
`ifdef FLOAT_DIV_TIMEOUT_EN
      wd        <= '0;
      out_err   <= 1'b0;
`endif
    end else begin
      div_enb <= 1'b0;
      case (state)
        IDLE: ;
        ISSUE: begin
          if (blank != '0) blank <= blank - BW'(1);
`ifdef FLOAT_DIV_TIMEOUT_EN
          wd <= wd + WW'(1);
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (blank != '0) blank <= blank - BW'(1);
`ifdef FLOAT_DIV_TIMEOUT_EN
          wd <= wd + WW'(1);
`endif
          if (ack_ok) begin
            out_c     <= div_c;
            out_valid <= 1'b1;
            state     <= OUT;
`ifdef FLOAT_DIV_TIMEOUT_EN
            out_err   <= 1'b0;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            out_c     <= DATA_WIDTH'(QNAN32);
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            state     <= OUT;
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        div_a   <= head[PW-1:DATA_WIDTH];
        div_b   <= head[DATA_WIDTH-1:0];
        div_enb <= 1'b1;
        blank   <= BW'(ACK_BLANK);
`ifdef FLOAT_DIV_TIMEOUT_EN
        wd      <= '0;
`endif
        state   <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_float_div_issuer.sv
// Bench for float_div_issuer: behavioural divider (ack 7 cycles after enb, held high),
// queue-based scoreboard for issue order and results, directed plus random traffic.
module tb_float_div_issuer;
  import float_div_pkg::*;

  localparam int unsigned TMO     = 64;
  localparam int          ACK_LAT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_c;
  logic        out_err;
  logic        div_enb;
  logic [31:0] div_a;
  logic [31:0] div_b;
  bit   [31:0] div_c;
  bit          div_ack;
  logic        busy;

  float_div_issuer #(.DATA_WIDTH(32), .DEPTH(4), .ACK_BLANK(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_err(out_err), .div_enb(div_enb), .div_a(div_a),
    .div_b(div_b), .div_c(div_c), .div_ack(div_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference quotients for the known vectors; other pairs get an arbitrary tag value.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4020_0000 && b == 32'h4080_0000) return 32'h3F20_0000;
    if (a == 32'h41B8_6666 && b == 32'h4000_0000) return 32'h4138_6666;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  // Divider model: result and level ack ACK_LAT cycles after enb, ack cleared by next enb.
  bit          no_ack = 1'b0;
  int          dcnt = 0;
  logic [31:0] dq;
  always @(posedge clk) begin
    if (div_enb) begin
      div_ack <= 1'b0;
      dcnt    <= no_ack ? 0 : ACK_LAT - 1;
      dq      <= quot(div_a, div_b);
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_ack <= 1'b1;
        div_c   <= dq;
      end
    end
  end

  // Scoreboard state.
  logic [63:0] issue_q[$];
  logic [32:0] exp_q[$];
  logic [63:0] pr;
  logic [32:0] ex;
  bit          mon_en = 1'b0;
  bit          prev_ov = 1'b0;
  bit          prev_enb = 1'b0;
  int          cyc = 0;
  int          last_enb = -100;
  int          enb_cnt = 0;
  int          res_cnt = 0;
  int          exp_lat = ACK_LAT + 1;

  // Monitor on the falling edge: issue order, enb spacing, result latency and data.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (div_enb) begin
        check("enb_pulse", 32'(prev_enb), 0);
        check("enb_gap", 32'((cyc - last_enb) > 8), 1);
        if (issue_q.size() == 0) check("enb_unexpected", 1, 0);
        else begin
          pr = issue_q.pop_front();
          check("div_a", div_a, pr[63:32]);
          check("div_b", div_b, pr[31:0]);
        end
        last_enb = cyc;
        enb_cnt++;
      end
      if (out_valid && !prev_ov) check("out_latency", 32'(cyc - last_enb), 32'(exp_lat));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          ex = exp_q.pop_front();
          check("out_c", out_c, ex[31:0]);
          check("out_err", 32'(out_err), 32'(ex[32]));
        end
        res_cnt++;
      end
      prev_ov  = out_valid;
      prev_enb = div_enb;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit err);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    else begin
      issue_q.push_back({a, b});
      exp_q.push_back(err ? {1'b1, QNAN32} : {1'b0, quot(a, b)});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n = 0;
    while (res_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (res_cnt < target) check("result_timeout", 32'(res_cnt), 32'(target));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int  base;
  int  enbs;
  bit  drv_done;

  initial begin
    // Reset state.
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_div_enb", 32'(div_enb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_err", 32'(out_err), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // T1: single op 2.5/4.
    out_ready = 1'b1;
    push_pair(32'h4020_0000, 32'h4080_0000, 1'b0);
    wait_results(1, 100);
    check("t1_enb_count", 32'(enb_cnt), 1);
    repeat (3) step();

    // T2: divider busy, then four back-to-back pushes fill the FIFO.
    base = res_cnt;
    push_pair(32'h3F80_0000, 32'h4000_0000, 1'b0);
    repeat (2) step();
    for (int i = 0; i < 4; i++) push_pair(32'h4100_0000 + 32'(i), 32'h4040_0000 + 32'(i), 1'b0);
    check("t2_full_in_ready", 32'(in_ready), 0);
    push_pair(32'h4110_0000, 32'h4050_0000, 1'b0);
    wait_results(base + 6, 400);
    check("t2_busy_idle", 32'(busy), 0);

    // T3: hold the first result for 20 cycles.
    base = res_cnt;
    out_ready = 1'b0;
    push_pair(32'h4220_0000, 32'h3FC0_0000, 1'b0);
    push_pair(32'h4230_0000, 32'h3FD0_0000, 1'b0);
    for (int n = 0; n < 100 && !out_valid; n++) step();
    check("t3_out_valid", 32'(out_valid), 1);
    enbs = enb_cnt;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_c", out_c, exp_q[0][31:0]);
    end
    check("t3_no_enb", 32'(enb_cnt), 32'(enbs));
    out_ready = 1'b1;
    step();
    check("t3_issue_next", 32'(div_enb), 1);
    wait_results(base + 2, 100);

    // T4: stale ack still high from the previous op at the new enb.
    base = res_cnt;
    push_pair(32'h41B8_6666, 32'h4000_0000, 1'b0);
    wait_results(base + 1, 100);

    // T5: reset during WAIT with two pairs queued.
    push_pair(32'h4300_0000, 32'h4000_0000, 1'b0);
    push_pair(32'h4310_0000, 32'h4000_0000, 1'b0);
    push_pair(32'h4320_0000, 32'h4000_0000, 1'b0);
    repeat (3) step();
    check("t5_pre_busy", 32'(busy), 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t5_div_enb", 32'(div_enb), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_c", out_c, 0);
    check("t5_div_a", div_a, 0);
    check("t5_in_ready", 32'(in_ready), 1);
    check("t5_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    issue_q.delete();
    exp_q.delete();
    prev_ov  = 1'b0;
    prev_enb = 1'b0;
    mon_en   = 1'b1;
    enbs     = enb_cnt;
    repeat (30) step();
    check("t5_no_enb", 32'(enb_cnt), 32'(enbs));
    check("t5_idle_busy", 32'(busy), 0);

`ifdef FLOAT_DIV_TIMEOUT_EN
    // T6: divider never acks; watchdog yields qNaN with error, next op is normal.
    base    = res_cnt;
    no_ack  = 1'b1;
    exp_lat = TMO;
    push_pair(32'h4400_0000, 32'h4000_0000, 1'b1);
    wait_results(base + 1, TMO + 50);
    no_ack  = 1'b0;
    repeat (2) step();
    exp_lat = ACK_LAT + 1;
    push_pair(32'h4020_0000, 32'h4080_0000, 1'b0);
    wait_results(base + 2, 100);
`endif

    // T7: random traffic with random consumer back-pressure.
    base     = res_cnt;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          push_pair($urandom, $urandom, 1'b0);
          repeat ($urandom_range(0, 2)) step();
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_ready = 1'b1;
    wait_results(base + 24, 600);

    repeat (3) step();
    check("final_exp_empty", 32'(exp_q.size()), 0);
    check("final_issue_empty", 32'(issue_q.size()), 0);
    check("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
